square_rebuild: RTL and testbench

SQUARE_REBUILD -- requirements
Module: square_rebuild

---
 rtl/square_rebuild_if.sv | 32 +++
 rtl/square_rebuild.sv | 165 ++++++++++++++++
 tb/tb_square_rebuild.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/square_rebuild_if.sv
// Handshake/operand bundle for square_rebuild.
// The requester drives start_i and the operands; the datapath
// returns busy/done, the reconstructed value and the range flag.
interface square_rebuild_if;
  logic       start_i;
  logic [3:0] y_i;
  logic [4:0] r_i;
  logic       busy_o;
  logic       done_o;
  logic [7:0] x_o;
  logic       err_o;

  modport master (
    output start_i,
    output y_i,
    output r_i,
    input  busy_o,
    input  done_o,
    input  x_o,
    input  err_o
  );

  modport slave (
    input  start_i,
    input  y_i,
    input  r_i,
    output busy_o,
    output done_o,
    output x_o,
    output err_o
  );
endinterface

// File: rtl/square_rebuild.sv
// square_rebuild: rebuilds x = y*y + r from a square-root result.
// Shift-and-add multiply over four cycles, with the accumulator
// preloaded with the remainder so the addition comes for free.
// Optional feature macro: SQUARE_RANGE_CHECK_EN
//   defined   -> r > 2*y flags err_o and leaves x_o untouched
//   undefined -> err_o tied low, x_o always takes the wrapped sum
module square_rebuild (
  input  logic            clk_i,
  input  logic            rst_i,
  square_rebuild_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [7:0] mcand;
  logic [3:0] mplr;
  logic [7:0] acc;
  logic [1:0] cnt;
  logic [7:0] x_q;
  logic       done_q;

  // One shift-and-add step; the 8-bit sum wraps modulo 256.
  function automatic logic [7:0] mac_step(input logic [7:0] a,
                                          input logic [7:0] m,
                                          input logic       bit0);
    logic [7:0] addend;
    addend   = bit0 ? m : 8'd0;
    mac_step = a + addend;
  endfunction

`ifdef SQUARE_RANGE_CHECK_EN
  logic [3:0] y_q;
  logic [4:0] r_q;
  logic       err_q;

  // A valid square-root remainder never exceeds 2*y.
  function automatic logic range_err(input logic [3:0] y,
                                     input logic [4:0] r);
    range_err = (r > {y, 1'b0});
  endfunction
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: IDLE -> MUL (4 steps) -> OUT -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          state_next = MUL;
        end
      end
      MUL: begin
        if (cnt == 2'd3) begin
          state_next = OUT;
        end
      end
      OUT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand latch and shift-and-add iteration.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand <= 8'd0;
      mplr  <= 4'd0;
      acc   <= 8'd0;
      cnt   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            mcand <= {4'b0000, bus.y_i};
            mplr  <= bus.y_i;
            acc   <= {3'b000, bus.r_i};
            cnt   <= 2'd0;
          end
        end
        MUL: begin
          acc   <= mac_step(acc, mcand, mplr[0]);
          mcand <= {mcand[6:0], 1'b0};
          mplr  <= {1'b0, mplr[3:1]};
          cnt   <= cnt + 2'd1;
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

`ifdef SQUARE_RANGE_CHECK_EN
  // Keep the raw operands for the range test performed in OUT.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      y_q <= 4'd0;
      r_q <= 5'd0;
    end else if ((state == IDLE) && bus.start_i) begin
      y_q <= bus.y_i;
      r_q <= bus.r_i;
    end
  end

  // Result publish: out-of-range operands hold x and raise err.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      x_q    <= 8'd0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == OUT);
      if (state == OUT) begin
        if (range_err(y_q, r_q)) begin
          err_q <= 1'b1;
        end else begin
          err_q <= 1'b0;
          x_q   <= acc;
        end
      end
    end
  end

  assign bus.err_o = err_q;
`else
  // Result publish: x takes the wrapped sum on every completion.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      x_q    <= 8'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == OUT);
      if (state == OUT) begin
        x_q <= acc;
      end
    end
  end

  assign bus.err_o = 1'b0;
`endif

  assign bus.busy_o = (state != IDLE);
  assign bus.done_o = done_q;
  assign bus.x_o    = x_q;

endmodule

// File: tb/tb_square_rebuild.sv
// Bench for square_rebuild: directed steps with a result scoreboard.
module tb_square_rebuild;
  logic clk = 1'b0;
  logic rst_n;

  square_rebuild_if bus();

  square_rebuild dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] x;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] x_model;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int isqrt(input int v);
    int q;
    q = 0;
    while ((q + 1) * (q + 1) <= v) q++;
    return q;
  endfunction

  task automatic push_expected(input logic [3:0] y, input logic [4:0] r);
    exp_t e;
    int   s;
    s     = int'(y) * int'(y) + int'(r);
    e.x   = s[7:0];
    e.err = 1'b0;
`ifdef SQUARE_RANGE_CHECK_EN
    if (int'(r) > 2 * int'(y)) begin
      e.err = 1'b1;
      e.x   = x_model;
    end
`endif
    x_model = e.x;
    sb.push_back(e);
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    n_checks++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_x"}, bus.x_o, e.x);
      check({tag, "_err"}, bus.err_o, e.err);
    end
  endtask

  // One operation from an idle DUT; ends on the negedge of the done cycle.
  task automatic run_op(input logic [3:0] y, input logic [4:0] r,
                        input string tag);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.y_i     = y;
    bus.r_i     = r;
    push_expected(y, r);
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 1) bus.start_i = 1'b0;
      check({tag, "_busy"}, bus.busy_o, (n < 6));
      check({tag, "_done"}, bus.done_o, (n == 6));
    end
    pop_compare(tag);
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.y_i     = 4'd0;
    bus.r_i     = 5'd0;
    x_model     = 8'd0;
    rst_n       = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_done", bus.done_o, 1'b0);
    check("rst_x", bus.x_o, 8'h00);
    check("rst_err", bus.err_o, 1'b0);
    rst_n = 1'b1;

    // Release alone must not start anything
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("rel_busy", bus.busy_o, 1'b0);
      check("rel_done", bus.done_o, 1'b0);
    end

    run_op(4'd0, 5'd0, "zero");
    check("zero_lit", bus.x_o, 8'h00);

    run_op(4'd15, 5'd0, "y15");
    check("y15_lit", bus.x_o, 8'hE1);

    run_op(4'd12, 5'd24, "y12");
    check("y12_lit", bus.x_o, 8'hA8);

    run_op(4'd3, 5'd7, "range");
`ifdef SQUARE_RANGE_CHECK_EN
    check("range_err_lit", bus.err_o, 1'b1);
    check("range_x_lit", bus.x_o, 8'hA8);
`else
    check("range_err_lit", bus.err_o, 1'b0);
    check("range_x_lit", bus.x_o, 8'd16);
`endif

    run_op(4'd15, 5'd31, "wrap");
`ifndef SQUARE_RANGE_CHECK_EN
    check("wrap_lit", bus.x_o, 8'h00);
`endif

    // Start during MUL is ignored
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.y_i     = 4'd5;
    bus.r_i     = 5'd2;
    push_expected(4'd5, 5'd2);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) bus.start_i = 1'b0;
      if (n == 2) begin
        bus.start_i = 1'b1;
        bus.y_i     = 4'd9;
        bus.r_i     = 5'd0;
      end
      if (n == 3) bus.start_i = 1'b0;
      if (n <= 6) check("ign_busy", bus.busy_o, (n < 6));
      check("ign_done", bus.done_o, (n == 6));
      if (n == 6) begin
        pop_compare("ign");
        check("ign_lit", bus.x_o, 8'd27);
      end
    end

    // Asynchronous reset during the third MUL cycle
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.y_i     = 4'd7;
    bus.r_i     = 5'd1;
    push_expected(4'd7, 5'd1);
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      if (n == 1) bus.start_i = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", bus.busy_o, 1'b0);
    check("arst_done", bus.done_o, 1'b0);
    check("arst_x", bus.x_o, 8'h00);
    check("arst_err", bus.err_o, 1'b0);
    sb.delete();
    x_model = 8'd0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("arst_nodone", bus.done_o, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_idle", bus.busy_o, 1'b0);
    run_op(4'd2, 5'd1, "post");
    check("post_lit", bus.x_o, 8'd5);

    // Start held high: one result every 6 cycles
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.y_i     = 4'd4;
    bus.r_i     = 5'd3;
    push_expected(4'd4, 5'd3);
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      check("held_busy", bus.busy_o, (n % 6 != 0));
      check("held_done", bus.done_o, (n % 6 == 0));
      if (n % 6 == 0) begin
        pop_compare("held");
        check("held_lit", bus.x_o, 8'd19);
        if (n < 18) push_expected(4'd4, 5'd3);
      end
      if (n == 18) bus.start_i = 1'b0;
    end
    @(negedge clk);
    check("held_stop", bus.busy_o, 1'b0);

    // Exhaustive sweep of valid pairs with square-root round trip
    for (int y = 0; y < 16; y++) begin
      for (int r = 0; r <= 2 * y; r++) begin
        run_op(y[3:0], r[4:0], "sweep");
        check("rt_y", isqrt(int'(bus.x_o)), y);
        check("rt_r", int'(bus.x_o) - isqrt(int'(bus.x_o)) * isqrt(int'(bus.x_o)), r);
      end
    end

    n_checks++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
